fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the 8-bit FIFO among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with bounded bursts.
// Writes are combinational in GRANT (no added latency); fifo_full stalls the owner without releasing the port.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0]    NREQ      = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [3:0]     LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [NUM_REQ-1:0] ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [IW-1:0]      owner, owner_nxt;
    logic [IW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [3:0]         beat_cnt, beat_cnt_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IW-1:0]      winner;
    logic [IW:0]        scan_idx;
    logic               found;
    logic               accept;
    logic               release_port;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant    <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            grant    <= grant_nxt;
        end
    end

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_idx >= NREQ)
                scan_idx = scan_idx - NREQ;
            if (!found && req_valid[scan_idx[IW-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[IW-1:0];
            end
        end
    end

    assign accept       = (state == GRANT) && req_valid[owner] && !fifo_full;
    assign release_port = (state == GRANT) &&
                          ((accept && (beat_cnt == LAST_BEAT)) || !req_valid[owner]);

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        grant_nxt    = grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    owner_nxt    = winner;
                    beat_cnt_nxt = '0;
                    grant_nxt    = ONE << winner;
                end
            end
            GRANT: begin
                if (release_port) begin
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                    grant_nxt    = '0;
                    rr_ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end else if (accept) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Outputs drive zero outside an accepted beat
    always_comb begin
        req_ready = '0;
        fifo_wr   = 1'b0;
        fifo_din  = '0;
        busy      = (state == GRANT);
        if (accept) begin
            req_ready = ONE << owner;
            fifo_wr   = 1'b1;
            fifo_din  = req_data[owner*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, fairness sequence, randomized run against a reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_wr;
    logic [W-1:0]   fifo_din;
    logic [N-1:0]   grant;
    logic           busy;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_din(fifo_din), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [31:0] d;
        logic        f;
        logic [3:0]  rdy;
        logic        wr;
        logic [7:0]  din;
        logic [3:0]  g;
        logic        b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic f,
                       input logic [3:0] rdy, input logic wr, input logic [7:0] din,
                       input logic [3:0] g, input logic b);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.f = f;
        t.rdy = rdy; t.wr = wr; t.din = din; t.g = g; t.b = b;
        vecs.push_back(t);
    endtask

    // Drive inputs just after a rising edge, return at the following falling edge for sampling
    task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d, input logic f);
        @(posedge clk);
        #1;
        rst = r; req_valid = v; req_data = d; fifo_full = f;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] pack_out(input logic [3:0] rdy, input logic wr,
                                             input logic [7:0] din, input logic [3:0] g, input logic b);
        return {rdy, wr, din, g, b};
    endfunction

    // Reference model: which requester holds the port, where the next search starts, beats taken
    int m_hold, m_next, m_taken;

    function automatic logic [17:0] model_out(input logic [3:0] v, input logic [31:0] d, input logic f);
        logic win;
        logic [3:0] oh;
        if (m_hold < 0) return '0;
        oh  = 4'b0001 << m_hold;
        win = v[m_hold] && !f;
        return pack_out(win ? oh : 4'b0000, win, win ? d[m_hold*8 +: 8] : 8'h00, oh, 1'b1);
    endfunction

    task automatic model_step(input logic r, input logic [3:0] v, input logic f);
        if (r) begin
            m_hold = -1; m_next = 0; m_taken = 0;
        end else if (m_hold < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_hold < 0 && v[(m_next + k) % N]) begin
                    m_hold  = (m_next + k) % N;
                    m_taken = 0;
                end
            end
        end else begin
            if (v[m_hold] && !f) m_taken++;
            if (!v[m_hold] || m_taken == MB) begin
                m_next = (m_hold + 1) % N;
                m_hold = -1;
            end
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0, 32'h0, 1'b0);
        drive(1'b1, 4'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [3:0]  rv;
        logic [31:0] rd;
        logic [3:0]  last_rdy;
        logic        rf, rr;
        logic [3:0]  prev_g;
        int          beats, ngr, idle_run, cyc;

        // ---------------- directed vector table ----------------
        //   rst  valid    data          full  ready   wr   din    grant   busy
        add(1, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b0001, 32'h00000011, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b0001, 32'h00000011, 0, 4'b0001, 1, 8'h11, 4'b0001, 1);
        add(0, 4'b0001, 32'h00000022, 0, 4'b0001, 1, 8'h22, 4'b0001, 1);
        add(0, 4'b0001, 32'h00000033, 0, 4'b0001, 1, 8'h33, 4'b0001, 1);
        add(0, 4'b0001, 32'h00000044, 0, 4'b0001, 1, 8'h44, 4'b0001, 1);
        add(0, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b1000, 32'hA1000000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b1000, 32'hA1000000, 0, 4'b1000, 1, 8'hA1, 4'b1000, 1);
        add(0, 4'b1000, 32'hA2000000, 0, 4'b1000, 1, 8'hA2, 4'b1000, 1);
        add(0, 4'b0001, 32'h00000055, 0, 4'b0000, 0, 8'h00, 4'b1000, 1);
        add(0, 4'b0011, 32'h00000055, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b0011, 32'h00000055, 0, 4'b0001, 1, 8'h55, 4'b0001, 1);
        add(0, 4'b0011, 32'h00000066, 1, 4'b0000, 0, 8'h00, 4'b0001, 1);
        add(0, 4'b0011, 32'h00000066, 1, 4'b0000, 0, 8'h00, 4'b0001, 1);
        add(0, 4'b0011, 32'h00000066, 1, 4'b0000, 0, 8'h00, 4'b0001, 1);
        add(0, 4'b0011, 32'h00000066, 0, 4'b0001, 1, 8'h66, 4'b0001, 1);
        add(0, 4'b0011, 32'h00000077, 0, 4'b0001, 1, 8'h77, 4'b0001, 1);
        add(0, 4'b0011, 32'h00000088, 0, 4'b0001, 1, 8'h88, 4'b0001, 1);
        add(0, 4'b0011, 32'h00009900, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b0011, 32'h00009900, 0, 4'b0010, 1, 8'h99, 4'b0010, 1);
        add(0, 4'b0011, 32'h00009A00, 0, 4'b0010, 1, 8'h9A, 4'b0010, 1);
        add(1, 4'b0000, 32'h00000000, 0, 4'b0000, 0, 8'h00, 4'b0010, 1);
        add(0, 4'b0011, 32'h0000005A, 0, 4'b0000, 0, 8'h00, 4'b0000, 0);
        add(0, 4'b0011, 32'h0000005A, 0, 4'b0001, 1, 8'h5A, 4'b0001, 1);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].f);
            check($sformatf("vec%0d", i),
                  32'(pack_out(req_ready, fifo_wr, fifo_din, grant, busy)),
                  32'(pack_out(vecs[i].rdy, vecs[i].wr, vecs[i].din, vecs[i].g, vecs[i].b)));
        end

        // ---------------- fairness: all requesters valid continuously ----------------
        do_reset();
        prev_g = '0; beats = 0; ngr = 0; idle_run = 0; cyc = 0;
        while (ngr < 20 && cyc < 400) begin
            drive(1'b0, 4'b1111, 32'hD3C2B1A0, 1'b0);
            cyc++;
            if (grant != 4'b0000) begin
                if (prev_g == 4'b0000) begin
                    if (ngr > 0) check("fair_gap", 32'(idle_run), 32'd1);
                    check("fair_order", 32'(grant), 32'(4'b0001 << (ngr % N)));
                    beats = 0;
                end
                if (req_ready != 4'b0000) begin
                    beats++;
                    check("fair_din", 32'(fifo_din), 32'(8'hA0 + 8'h11 * (ngr % N)));
                end
                idle_run = 0;
            end else begin
                if (prev_g != 4'b0000) begin
                    check("fair_beats", 32'(beats), 32'(MB));
                    ngr++;
                end
                idle_run++;
            end
            prev_g = grant;
        end
        check("fair_grant_count", 32'(ngr), 32'd20);

        // ---------------- randomized run against reference model ----------------
        do_reset();
        m_hold = -1; m_next = 0; m_taken = 0;
        rv = '0; rd = '0; last_rdy = '0;
        for (int c = 0; c < 3000; c++) begin
            rr = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(rv[i] && !last_rdy[i] && $urandom_range(0, 7) != 0)) begin
                    rv[i]         = ($urandom_range(0, 2) != 0);
                    rd[i*8 +: 8]  = 8'($urandom);
                end
            end
            rf = ($urandom_range(0, 3) == 0);
            if (rr) rv = '0;
            drive(rr, rv, rd, rf);
            check("rand_out", 32'(pack_out(req_ready, fifo_wr, fifo_din, grant, busy)),
                  32'(model_out(rv, rd, rf)));
            check("rand_onehot_ready", 32'($countones(req_ready) <= 1), 32'd1);
            check("rand_no_wr_full", 32'(fifo_wr && fifo_full), 32'd0);
            last_rdy = req_ready;
            model_step(rr, rv, rf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
